// File: rtl/spi_pkg.sv
// Shared definitions for the SPI configuration link.
// The configuration master and the engine's SPI receiver both import this
// package, so the two ends agree on frame width and bus mode.
//   FRAME_WIDTH_DEFAULT : bits per configuration frame
//   SPI_CPOL/SPI_CPHA   : mode 0 (clock idles low, data sampled on rising edge)
//   spi_state_e         : master sequencing states
package spi_pkg;

  localparam int FRAME_WIDTH_DEFAULT = 16;

  // Mode 0: spiClk idles low, receiver samples mosi on the rising edge,
  // transmitter changes mosi on the falling edge. MSB first.
  localparam logic SPI_CPOL = 1'b0;
  localparam logic SPI_CPHA = 1'b0;
  localparam logic [1:0] SPI_MODE = {SPI_CPOL, SPI_CPHA};

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    GAP   = 3'd4
  } spi_state_e;

endpackage

// File: rtl/spi_config_master_if.sv
// Request/bus bundle between the frame source and the SPI configuration master.
//   txData/txValid/txReady : word request handshake (txData sampled on accept)
//   busy/done              : frame status (done pulses when cs deasserts)
//   cs/mosi/spiClk         : SPI bus towards the engine's receiver
// master modport: the SPI master itself. slave modport: frame source / bus observer.
interface spi_config_master_if
  import spi_pkg::*;
#(
  parameter int FRAME_WIDTH = FRAME_WIDTH_DEFAULT
);

  logic [FRAME_WIDTH-1:0] txData;
  logic                   txValid;
  logic                   txReady;
  logic                   busy;
  logic                   done;
  logic                   cs;
  logic                   mosi;
  logic                   spiClk;

  modport master (
    input  txData, txValid,
    output txReady, busy, done, cs, mosi, spiClk
  );

  modport slave (
    output txData, txValid,
    input  txReady, busy, done, cs, mosi, spiClk
  );

endinterface

// File: rtl/spi_clk_divider.sv
// Phase counter for the SPI master. Counts 0..CLK_DIV-1 and flags the last
// cycle of each phase with a one-cycle tick.
//   clk   : system clock
//   reset : synchronous active-high reset
//   clear : hold the counter at 0 (used while the master is idle, so every
//           frame starts from a fresh phase)
//   tick  : high during the last cycle of each CLK_DIV-cycle phase
// CLK_DIV must be >= 2 so the receiver's synchroniser can see spiClk.
module spi_clk_divider
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/spi_config_master.sv
// SPI mode-0 transmitter for FIR-engine configuration frames. Each accepted
// request serialises one FRAME_WIDTH-bit word MSB first on cs/mosi/spiClk.
//   clk   : system clock
//   reset : synchronous active-high reset; aborts any frame (cs rises, no done)
//   bus   : request handshake, status and SPI pins (master modport)
// Sequence per frame: IDLE -> SETUP (cs low, MSB on mosi, one half-period)
// -> SHIFT (FRAME_WIDTH clock pulses) -> HOLD (LSB held one half-period)
// -> GAP (cs high one half-period before the next request is taken).
// All outputs are registered.
module spi_config_master
  import spi_pkg::*;
#(
  parameter int FRAME_WIDTH = FRAME_WIDTH_DEFAULT,
  parameter int CLK_DIV     = 4
) (
  input logic                 clk,
  input logic                 reset,
  spi_config_master_if.master bus
);

  localparam logic [2:0] ST_IDLE  = IDLE;
  localparam logic [2:0] ST_SETUP = SETUP;
  localparam logic [2:0] ST_SHIFT = SHIFT;
  localparam logic [2:0] ST_HOLD  = HOLD;
  localparam logic [2:0] ST_GAP   = GAP;

  localparam int BW = (FRAME_WIDTH > 1) ? $clog2(FRAME_WIDTH) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(FRAME_WIDTH - 1);

  logic [2:0]             state;
  logic [FRAME_WIDTH-1:0] shreg;
  logic [BW-1:0]          bit_cnt;
  logic                   tick;
  logic                   div_clear;

  // Holding the divider in IDLE makes the first phase of every frame exactly
  // CLK_DIV cycles long, measured from the cycle cs falls.
  assign div_clear = (state == ST_IDLE);

  spi_clk_divider #(
    .CLK_DIV(CLK_DIV)
  ) u_div (
    .clk  (clk),
    .reset(reset),
    .clear(div_clear),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      shreg       <= '0;
      bit_cnt     <= '0;
      bus.cs      <= 1'b1;
      bus.spiClk  <= 1'b0;
      bus.mosi    <= 1'b0;
      bus.txReady <= 1'b1;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.txValid && bus.txReady) begin
            state       <= ST_SETUP;
            shreg       <= bus.txData;
            bit_cnt     <= '0;
            bus.mosi    <= bus.txData[FRAME_WIDTH-1];
            bus.cs      <= 1'b0;
            bus.txReady <= 1'b0;
            bus.busy    <= 1'b1;
          end
        end
        ST_SETUP: begin
          if (tick) begin
            bus.spiClk <= 1'b1;
            state      <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (tick) begin
            if (bus.spiClk) begin
              bus.spiClk <= 1'b0;
              // The last falling edge leaves the LSB on mosi through HOLD.
              if (bit_cnt == LAST_BIT) begin
                state <= ST_HOLD;
              end else begin
                bus.mosi <= shreg[FRAME_WIDTH-2];
                shreg    <= shreg << 1;
                bit_cnt  <= bit_cnt + 1'b1;
              end
            end else begin
              bus.spiClk <= 1'b1;
            end
          end
        end
        ST_HOLD: begin
          if (tick) begin
            bus.cs   <= 1'b1;
            bus.mosi <= 1'b0;
            bus.done <= 1'b1;
            state    <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (tick) begin
            bus.txReady <= 1'b1;
            bus.busy    <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_config_master.sv
// Directed bench for spi_config_master: a 16-bit/CLK_DIV=4 instance and an
// 8-bit/CLK_DIV=2 instance. Negedge monitors decode the SPI bus (mosi sampled
// on each spiClk rise) and time-stamp cs, done and txReady; stimulus changes
// 1 time unit after each rising edge.
module tb_spi_config_master;
  import spi_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  spi_config_master_if #(.FRAME_WIDTH(16)) bus_a ();
  spi_config_master_if #(.FRAME_WIDTH(8))  bus_b ();

  spi_config_master #(.FRAME_WIDTH(16), .CLK_DIV(4)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a)
  );
  spi_config_master #(.FRAME_WIDTH(8), .CLK_DIV(2)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b)
  );

  int n_cmp = 0;
  int n_err = 0;

  // ---------------- bus monitor, 16-bit instance ----------------
  logic pa_clk = 1'b0, pa_cs = 1'b1, pa_rdy = 1'b1;
  int a_fall = -1, a_first = -1, a_last = -1, a_done_cyc = -1, a_rdy_cyc = -1;
  int a_rise_n = 0, a_done_n = 0, a_csrise = -1, a_gap = -1, a_viol = 0;
  logic [15:0] a_word = '0;
  logic [15:0] a_words[$];

  always @(negedge clk) begin
    if (pa_cs && !bus_a.cs) begin
      a_gap = cyc - a_csrise;
      a_fall = cyc; a_first = -1; a_last = -1; a_rise_n = 0;
      a_word = '0; a_done_cyc = -1; a_rdy_cyc = -1;
    end
    if (!pa_clk && bus_a.spiClk) begin
      a_word = {a_word[14:0], bus_a.mosi};
      a_rise_n++;
      if (a_first < 0) a_first = cyc;
      a_last = cyc;
    end
    if (bus_a.done) begin
      a_done_n++;
      a_done_cyc = cyc;
      a_words.push_back(a_word);
    end
    if (!pa_cs && bus_a.cs) a_csrise = cyc;
    if (!pa_rdy && bus_a.txReady) a_rdy_cyc = cyc;
    if (!reset && bus_a.cs && bus_a.spiClk) a_viol++;
    pa_clk = bus_a.spiClk; pa_cs = bus_a.cs; pa_rdy = bus_a.txReady;
  end

  // ---------------- bus monitor, 8-bit instance ----------------
  logic pb_clk = 1'b0, pb_cs = 1'b1, pb_rdy = 1'b1;
  int b_fall = -1, b_first = -1, b_done_cyc = -1, b_rdy_cyc = -1;
  int b_rise_n = 0, b_done_n = 0, b_viol = 0;
  logic [7:0] b_word = '0, b_got = '0;

  always @(negedge clk) begin
    if (pb_cs && !bus_b.cs) begin
      b_fall = cyc; b_first = -1; b_rise_n = 0;
      b_word = '0; b_done_cyc = -1; b_rdy_cyc = -1;
    end
    if (!pb_clk && bus_b.spiClk) begin
      b_word = {b_word[6:0], bus_b.mosi};
      b_rise_n++;
      if (b_first < 0) b_first = cyc;
    end
    if (bus_b.done) begin
      b_done_n++;
      b_done_cyc = cyc;
      b_got = b_word;
    end
    if (!pb_rdy && bus_b.txReady) b_rdy_cyc = cyc;
    if (!reset && bus_b.cs && bus_b.spiClk) b_viol++;
    pb_clk = bus_b.spiClk; pb_cs = bus_b.cs; pb_rdy = bus_b.txReady;
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic tick_n(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_ready_a();
    int n = 0;
    while (!bus_a.txReady && n < 400) begin
      tick_n(1);
      n++;
    end
    chk("ready_wait_a", int'(n < 400), 1);
  endtask

  // Returns t = the cycle in which txValid && txReady is presented.
  task automatic send_a(input logic [15:0] d, output int t);
    wait_ready_a();
    bus_a.txData = d;
    bus_a.txValid = 1'b1;
    t = cyc;
    tick_n(1);
    bus_a.txValid = 1'b0;
  endtask

  function automatic logic [15:0] last_word_a(input int back);
    if (a_words.size() > back) return a_words[a_words.size() - 1 - back];
    return 16'hxxxx;
  endfunction

  task automatic check_frame_a(input string tag, input int t, input logic [15:0] exp);
    chk({tag, "_word"},       int'(last_word_a(0)), int'(exp));
    chk({tag, "_rises"},      a_rise_n,   16);
    chk({tag, "_cs_low"},     a_fall,     t + 1);
    chk({tag, "_first_rise"}, a_first,    t + 5);
    chk({tag, "_last_rise"},  a_last,     t + 125);
    chk({tag, "_done"},       a_done_cyc, t + 133);
    chk({tag, "_ready"},      a_rdy_cyc,  t + 137);
  endtask

  typedef struct {
    string       name;
    logic [15:0] data;
    logic [15:0] exp_word;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int t, t2, d0, early;

    vecs[0] = '{"a5c3", 16'hA5C3, 16'hA5C3};
    vecs[1] = '{"0001", 16'h0001, 16'h0001};
    vecs[2] = '{"8000", 16'h8000, 16'h8000};
    vecs[3] = '{"ffff", 16'hFFFF, 16'hFFFF};
    vecs[4] = '{"5a96", 16'h5A96, 16'h5A96};

    bus_a.txData = '0; bus_a.txValid = 1'b0;
    bus_b.txData = '0; bus_b.txValid = 1'b0;

    // Reset values
    tick_n(3);
    chk("rst_cs",      bus_a.cs,      1);
    chk("rst_spiclk",  bus_a.spiClk,  0);
    chk("rst_mosi",    bus_a.mosi,    0);
    chk("rst_txready", bus_a.txReady, 1);
    chk("rst_busy",    bus_a.busy,    0);
    chk("rst_done",    bus_a.done,    0);
    reset = 1'b0;
    tick_n(2);
    chk("idle_cs", bus_a.cs, 1);

    // Single frames from the table
    for (int i = 0; i < 5; i++) begin
      d0 = a_done_n;
      send_a(vecs[i].data, t);
      tick_n(138);
      check_frame_a(vecs[i].name, t, vecs[i].exp_word);
      chk({vecs[i].name, "_done_cnt"}, a_done_n - d0, 1);
    end

    // Back-to-back with txValid held high
    wait_ready_a();
    d0 = a_done_n;
    bus_a.txData = 16'h0001;
    bus_a.txValid = 1'b1;
    t = cyc;
    tick_n(1);
    bus_a.txData = 16'h8000;
    while (cyc < t + 137) tick_n(1);
    chk("b2b_ready_at_137", bus_a.txReady, 1);
    tick_n(1);
    bus_a.txValid = 1'b0;
    t2 = t + 137;
    tick_n(140);
    chk("b2b_second_cs_low", a_fall, t + 138);
    chk("b2b_cs_high_gap",   a_gap,  5);
    chk("b2b_word1", int'(last_word_a(1)), 16'h0001);
    chk("b2b_word2", int'(last_word_a(0)), 16'h8000);
    chk("b2b_done_cnt", a_done_n - d0, 2);
    chk("b2b_second_done", a_done_cyc, t2 + 133);

    // Input changes after accept have no effect; busy-time requests ignored
    wait_ready_a();
    d0 = a_done_n;
    bus_a.txData = 16'h1234;
    bus_a.txValid = 1'b1;
    t = cyc;
    tick_n(1);
    early = 0;
    for (int i = 1; i <= 136; i++) begin
      bus_a.txData = i[0] ? 16'hFFFF : 16'h0F0F;
      bus_a.txValid = i[0];
      if (bus_a.txReady) early++;
      tick_n(1);
    end
    bus_a.txValid = 1'b0;
    chk("hold_ready_low_cycles", early, 0);
    chk("hold_ready_at_137", bus_a.txReady, 1);
    tick_n(5);
    chk("hold_no_queued_frame", bus_a.cs, 1);
    chk("hold_word", int'(last_word_a(0)), 16'h1234);
    chk("hold_done_cnt", a_done_n - d0, 1);
    chk("hold_ready_cyc", a_rdy_cyc, t + 137);

    // Reset mid-frame
    d0 = a_done_n;
    send_a(16'hFFFF, t);
    while (cyc < t + 60) tick_n(1);
    chk("pre_rst_cs_low", bus_a.cs, 0);
    reset = 1'b1;
    tick_n(1);
    chk("midrst_cs",      bus_a.cs,      1);
    chk("midrst_spiclk",  bus_a.spiClk,  0);
    chk("midrst_mosi",    bus_a.mosi,    0);
    chk("midrst_txready", bus_a.txReady, 1);
    chk("midrst_busy",    bus_a.busy,    0);
    reset = 1'b0;
    tick_n(140);
    chk("midrst_no_done", a_done_n - d0, 0);

    // Reset and txValid together: nothing accepted
    bus_a.txData = 16'hAAAA;
    bus_a.txValid = 1'b1;
    reset = 1'b1;
    tick_n(1);
    bus_a.txValid = 1'b0;
    reset = 1'b0;
    chk("rstvalid_cs", bus_a.cs, 1);
    tick_n(1);
    chk("rstvalid_busy", bus_a.busy, 0);

    // Frame after reset
    d0 = a_done_n;
    send_a(16'h00FF, t);
    tick_n(138);
    check_frame_a("post_rst", t, 16'h00FF);
    chk("post_rst_done_cnt", a_done_n - d0, 1);

    // 8-bit / CLK_DIV=2 instance
    d0 = b_done_n;
    bus_b.txData = 8'h3C;
    bus_b.txValid = 1'b1;
    t = cyc;
    tick_n(1);
    bus_b.txValid = 1'b0;
    tick_n(40);
    chk("small_word",       int'(b_got), 8'h3C);
    chk("small_rises",      b_rise_n,    8);
    chk("small_cs_low",     b_fall,      t + 1);
    chk("small_first_rise", b_first,     t + 3);
    chk("small_done",       b_done_cyc,  t + 35);
    chk("small_ready",      b_rdy_cyc,   t + 37);
    chk("small_done_cnt",   b_done_n - d0, 1);

    chk("sclk_while_cs_high_a", a_viol, 0);
    chk("sclk_while_cs_high_b", b_viol, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/spi_config_master.md
Name: spi_config_master

Overview:
- SPI transmitter (bus master) for FIR-engine configuration frames: serialises one FRAME_WIDTH-bit word onto cs/mosi/spiClk per accepted request.
- It is the other end of the engine's SPI configuration receiver.
- On the Basys3 build it drives the engine's SPI inputs from on-board logic (switches/ROM sequencer), so coefficients and scales can be loaded without an external host.
- SPI mode 0, MSB first.

Parameters:
- FRAME_WIDTH, 16, bits per frame.
- CLK_DIV, 4, clk cycles per spiClk half-period. Must be >= 2 so the receiver's synchroniser can sample spiClk.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- txData  input  FRAME_WIDTH  word to send; sampled only on accept
- txValid  input  1  request to send txData
- txReady  output  1  high when a request can be accepted
- busy  output  1  frame in progress (cs low, or post-frame gap)
- done  output  1  one-cycle pulse when cs deasserts at frame end
- cs  output  1  chip select, active low
- mosi  output  1  serial data
- spiClk  output  1  SPI clock, idle low

Behaviour:
- Reset: all outputs are registered. Reset values:
  - cs=1, spiClk=0, mosi=0, txReady=1, busy=0, done=0
  - state=IDLE, counters=0
- Accept: txValid && txReady sampled at edge T.
  - txData is latched into the shift register.
  - txValid or txData changes after T have no effect until txReady returns.
  - txValid while txReady=0 is ignored and never queued.
- States: IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> IDLE.
- Phase counter: counts 0..CLK_DIV-1. A tick marks each phase end.
- Timing, all relative to accept edge T (N=FRAME_WIDTH, D=CLK_DIV):
  - T+1: cs=0, mosi=MSB, txReady=0, busy=1 (SETUP).
  - T+1+D: spiClk rises (first bit); SHIFT entered.
  - Bit k (k=0..N-1): spiClk high during [T+1+D+2kD, T+1+2D+2kD), low for the next D cycles.
  - On each falling edge except the last, mosi updates to the next bit in the same cycle. mosi is therefore stable a full half-period around every rising edge.
  - T+1+2ND: last falling edge; mosi holds the LSB; HOLD entered.
  - T+1+(2N+1)D: cs=1, done=1 for exactly one cycle, mosi=0; GAP entered.
  - T+1+(2N+2)D: txReady=1, busy=0; IDLE.
- Defaults (N=16, D=4):
  - cs low T+1
  - first rise T+5
  - last rise T+125
  - last fall T+129
  - cs high / done T+133
  - txReady T+137
- Exactly N rising edges of spiClk per frame. spiClk is never high while cs=1.
- Back-to-back: a request accepted in the cycle txReady rises starts the next frame. cs then stays high for D+1 cycles between frames (5 at defaults).
- Reset mid-frame: on the next edge all outputs take their reset values.
  - Frame is aborted, no done pulse.
  - The receiver sees cs rise, which discards the partial frame.
- Reset and txValid in the same cycle: reset wins, nothing is accepted.
- Shift register: left shift, zero fill. Bit count is 0..N-1 with width $clog2(N).

Decomposition:
- Shared package spi_pkg contains:
  - the state enum typedef (IDLE, SETUP, SHIFT, HOLD, GAP)
  - a mode-0 CPOL/CPHA constant documenting the bus convention
  - the FRAME_WIDTH default, shared with the engine's SPI receiver so both ends agree
- Sub-module spi_clk_divider:
  - phase counter, CLK_DIV parameter
  - inputs: clk, reset, clear
  - output: a one-cycle tick
  - the FSM in spi_config_master consumes the tick

Test Plan:
1. Defaults; send 0xA5C3.
   - Bench samples mosi on each spiClk rise: 16 bits = 1010_0101_1100_0011.
   - cs low T+1, first rise T+5, done only at T+133, txReady T+137.
2. txValid held high with 0x0001 then 0x8000.
   - Second frame: cs low at T+138, giving 5 cycles of cs high between frames.
   - Decoded words: 0x0001, 0x8000.
   - done pulses exactly twice.
3. txData toggled to 0xFFFF every cycle after accepting 0x1234; txValid pulsed while busy.
   - Transmitted word is 0x1234, exactly one frame, txReady stays 0 until T+137.
4. reset asserted at T+60 during 0xFFFF.
   - At T+61: cs=1, spiClk=0, mosi=0, txReady=1, done never pulses.
   - A subsequent 0x00FF frame decodes correctly.
5. FRAME_WIDTH=8, CLK_DIV=2; send 0x3C.
   - 8 rising edges, decoded 0x3C.
   - done at T+35, txReady at T+37.
6. Loopback: master drives the engine's SPI receiver with defaults; send a scale word.
   - Receiver register updates to the sent value after cs rises.
   - spiClk never high while cs=1 (assertion).
